// File: rtl/alu_exec_if.sv
// Handshake bundle between the issue side (operands in) and the
// writeback side (result out) of the execute-stage ALU.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  // Driver of operands and consumer of results
  modport master (
    output in_valid, funct, src_a, src_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // The ALU itself
  modport slave (
    input  in_valid, funct, src_a, src_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle addu/subu/and, iterative 1-bit-per-cycle
// sll. One-entry registered result with valid/ready on both sides.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam logic [5:0] FN_ADDU = 6'b001001;
  localparam logic [5:0] FN_SUBU = 6'b001010;
  localparam logic [5:0] FN_AND  = 6'b010001;
  localparam logic [5:0] FN_SLL  = 6'b100001;

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_count;
  logic [WIDTH-1:0] r_shift_reg;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_start_shift;
  logic             w_load_single;
  logic             w_shift_done;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_calc;
  logic             w_calc_illegal;

  // in_ready depends only on registered state and out_ready (one gate from out_ready)
  assign w_in_ready    = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  // A zero-length shift takes the single-cycle path
  assign w_start_shift = w_accept && (bus.funct == FN_SLL) && (bus.shamt != 5'd0);
  assign w_load_single = w_accept && !w_start_shift;
  // The last shift step is the one that takes count from 1 to 0
  assign w_shift_done  = (r_state == ST_SHIFT) && (r_count <= 5'd1);
  assign w_shift_next  = {r_shift_reg[WIDTH-2:0], 1'b0};

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

  // Single-cycle datapath; unknown codes yield 0 and flag illegal
  always_comb begin
    w_calc         = '0;
    w_calc_illegal = 1'b0;
    case (bus.funct)
      FN_ADDU: w_calc = bus.src_a + bus.src_b;
      FN_SUBU: w_calc = bus.src_a - bus.src_b;
      FN_AND:  w_calc = bus.src_a & bus.src_b;
      FN_SLL:  w_calc = bus.src_b;
      default: w_calc_illegal = 1'b1;
    endcase
  end

  // Next-state logic: enter SHIFT on a non-zero sll, leave on the last step
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_shift) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_shift_done)  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Iterative shifter: load on accept, then one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_reg <= '0;
      r_count     <= 5'd0;
    end else if (w_start_shift) begin
      r_shift_reg <= bus.src_b;
      r_count     <= bus.shamt;
    end else if (r_state == ST_SHIFT) begin
      r_shift_reg <= w_shift_next;
      r_count     <= r_count - 5'd1;
    end
  end

  // Result register: load from shifter or single-cycle path, else drain/hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_shift_done) begin
      r_result    <= w_shift_next;
      r_zero      <= (w_shift_next == '0);
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_load_single) begin
      r_result    <= w_calc;
      r_zero      <= (w_calc == '0);
      r_illegal   <= w_calc_illegal;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table of single-cycle ops plus
// hand-written sll, backpressure and mid-shift reset sequences.
module tb_alu_exec;
  localparam logic [5:0] FN_ADDU = 6'b001001;
  localparam logic [5:0] FN_SUBU = 6'b001010;
  localparam logic [5:0] FN_AND  = 6'b010001;
  localparam logic [5:0] FN_SLL  = 6'b100001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs [10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{FN_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{FN_SUBU, 32'h0000_0005, 32'h0000_0007, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{FN_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[3] = '{FN_ADDU, 32'h1234_5678, 32'h1111_1111, 5'd0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[4] = '{FN_SLL,  32'hDEAD_BEEF, 32'h0000_0003, 5'd0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[5] = '{6'b000000, 32'h0000_0009, 32'h0000_0009, 5'd0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{FN_SUBU, 32'h0000_0009, 32'h0000_0009, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{6'b100010, 32'h0000_0001, 32'h0000_0002, 5'd7, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{FN_SLL,  32'h0, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[9] = '{FN_AND,  32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 32'h0000_0000, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.funct     = 6'd0;
    bus.src_a     = 32'd0;
    bus.src_b     = 32'd0;
    bus.shamt     = 5'd0;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    #12;
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check32("reset_result", bus.result, 32'h0);
    check1("reset_zero", bus.zero, 1'b0);
    check1("reset_illegal", bus.illegal, 1'b0);
    rst_n = 1'b1;
    step();
    check1("post_reset_in_ready", bus.in_ready, 1'b1);

    // Back-to-back single-cycle vectors, one per cycle
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.funct    = vecs[i].funct;
      bus.src_a    = vecs[i].a;
      bus.src_b    = vecs[i].b;
      bus.shamt    = vecs[i].shamt;
      #1;
      check1($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
      step();
      check1($sformatf("vec%0d_out_valid", i), bus.out_valid, 1'b1);
      check32($sformatf("vec%0d_result", i), bus.result, vecs[i].exp_result);
      check1($sformatf("vec%0d_zero", i), bus.zero, vecs[i].exp_zero);
      check1($sformatf("vec%0d_illegal", i), bus.illegal, vecs[i].exp_illegal);
      $display("vec %0d funct=%b a=%h b=%h -> result=%h zero=%b illegal=%b",
               i, vecs[i].funct, vecs[i].a, vecs[i].b, bus.result, bus.zero, bus.illegal);
    end

    // sll by 4: result exactly 4 cycles after acceptance, in_ready low meanwhile
    bus.funct = FN_SLL;
    bus.src_a = 32'h0;
    bus.src_b = 32'h0000_0003;
    bus.shamt = 5'd4;
    #1;
    check1("sll4_in_ready_before", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    check1("sll4_in_ready_k", bus.in_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) begin
        check1($sformatf("sll4_in_ready_%0d", i), bus.in_ready, 1'b0);
        check1($sformatf("sll4_out_valid_%0d", i), bus.out_valid, 1'b0);
      end else begin
        check1("sll4_out_valid", bus.out_valid, 1'b1);
        check32("sll4_result", bus.result, 32'h0000_0030);
        check1("sll4_zero", bus.zero, 1'b0);
        check1("sll4_illegal", bus.illegal, 1'b0);
        check1("sll4_in_ready_after", bus.in_ready, 1'b1);
      end
    end
    $display("sll b=3 shamt=4 -> result=%h", bus.result);

    // sll by 0: single-cycle path
    bus.in_valid = 1'b1;
    bus.shamt    = 5'd0;
    step();
    bus.in_valid = 1'b0;
    check1("sll0_out_valid", bus.out_valid, 1'b1);
    check32("sll0_result", bus.result, 32'h0000_0003);
    check1("sll0_in_ready", bus.in_ready, 1'b1);
    $display("sll b=3 shamt=0 -> result=%h", bus.result);
    step();
    check1("drain_out_valid", bus.out_valid, 1'b0);

    // Backpressure: buffered result held, new op waits
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.funct     = FN_ADDU;
    bus.src_a     = 32'd1;
    bus.src_b     = 32'd2;
    step();
    check32("bp_first_result", bus.result, 32'd3);
    bus.src_a = 32'd10;
    bus.src_b = 32'd20;
    #1;
    check1("bp_in_ready_low", bus.in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check1($sformatf("bp_hold_valid_%0d", i), bus.out_valid, 1'b1);
      check32($sformatf("bp_hold_result_%0d", i), bus.result, 32'd3);
      check1($sformatf("bp_hold_in_ready_%0d", i), bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    check1("bp_in_ready_release", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check1("bp_new_valid", bus.out_valid, 1'b1);
    check32("bp_new_result", bus.result, 32'd30);
    $display("backpressure release -> result=%h", bus.result);
    step();
    check1("bp_drained", bus.out_valid, 1'b0);

    // Mid-shift reset: illegal op leaves illegal=1 held, then sll by 20
    bus.in_valid = 1'b1;
    bus.funct    = 6'b111111;
    step();
    bus.funct = FN_SLL;
    bus.src_b = 32'h0000_0001;
    bus.shamt = 5'd20;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check1("rst_pre_in_ready", bus.in_ready, 1'b0);
    check1("rst_pre_illegal", bus.illegal, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rst_async_out_valid", bus.out_valid, 1'b0);
    check1("rst_async_zero", bus.zero, 1'b0);
    check1("rst_async_illegal", bus.illegal, 1'b0);
    check32("rst_async_result", bus.result, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check1("rst_release_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid !== 1'b0)
        check1($sformatf("rst_discard_%0d", i), bus.out_valid, 1'b0);
    end
    check1("rst_discard_final", bus.out_valid, 1'b0);
    $display("mid-shift reset -> out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);

    // Unit still works after reset
    bus.in_valid = 1'b1;
    bus.funct    = FN_SUBU;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd1;
    step();
    bus.in_valid = 1'b0;
    check32("post_rst_result", bus.result, 32'd99);
    check1("post_rst_valid", bus.out_valid, 1'b1);
    $display("post-reset subu 100-1 -> result=%h", bus.result);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
